// File: rtl/layer3_pool_pixel_buffer.sv
// Four-bank frame buffer between the layer-2 save port and the layer-3 2x2 max pooler.
// Pixels are banked by {row[0], col[0]}, so a single read returns a whole pooling window.
module layer3_pool_pixel_buffer #(
    parameter int DATA_W  = 128,
    parameter int IN_ROWS = 16,
    parameter int IN_COLS = 16,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              save_enable,
    input  logic [ADDR_W-1:0] save_row,
    input  logic [ADDR_W-1:0] save_col,
    input  logic [DATA_W-1:0] save_data,
    input  logic              read_pixel_signal,
    input  logic [ADDR_W-1:0] read_row_addr,
    input  logic [ADDR_W-1:0] read_col_addr,
    input  logic              layer3_calculation_done,
    output logic              pixel_store_done,
    output logic [DATA_W-1:0] input_data_even_even,
    output logic [DATA_W-1:0] input_data_even_odd,
    output logic [DATA_W-1:0] input_data_odd_even,
    output logic [DATA_W-1:0] input_data_odd_odd,
    output logic              write_drop
);

    localparam int TOTAL      = IN_ROWS * IN_COLS;
    localparam int BANK_DEPTH = TOTAL / 4;
    localparam int BA_W       = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
    localparam int CNT_W      = $clog2(TOTAL + 1);

    localparam logic [ADDR_W-1:0] ROWS_L     = ADDR_W'(IN_ROWS);
    localparam logic [ADDR_W-1:0] COLS_L     = ADDR_W'(IN_COLS);
    localparam logic [ADDR_W-1:0] HALF_ROWS  = ADDR_W'(IN_ROWS / 2);
    localparam logic [ADDR_W-1:0] HALF_COLS  = ADDR_W'(IN_COLS / 2);
    localparam logic [BA_W-1:0]   BANK_PITCH = BA_W'(IN_COLS / 2);
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(TOTAL - 1);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  wr_cnt, wr_cnt_next;
    logic              store_done_next;
    logic              drop_next;

    logic              wr_accept;
    logic [1:0]        wr_bank;
    logic [BA_W-1:0]   wr_addr;
    logic              rd_valid;
    logic [BA_W-1:0]   rd_addr;

    logic [DATA_W-1:0] bank_ee [BANK_DEPTH];
    logic [DATA_W-1:0] bank_eo [BANK_DEPTH];
    logic [DATA_W-1:0] bank_oe [BANK_DEPTH];
    logic [DATA_W-1:0] bank_oo [BANK_DEPTH];

    always_comb begin
        wr_accept = save_enable && (state == FILL) && (save_row < ROWS_L) && (save_col < COLS_L);
        wr_bank   = {save_row[0], save_col[0]};
        wr_addr   = BA_W'(save_row >> 1) * BANK_PITCH + BA_W'(save_col >> 1);
        rd_valid  = (read_row_addr < HALF_ROWS) && (read_col_addr < HALF_COLS);
        rd_addr   = BA_W'(read_row_addr) * BANK_PITCH + BA_W'(read_col_addr);
    end

    // Completion is by write count; a completing write beats a coincident calculation-done.
    always_comb begin
        state_next      = state;
        wr_cnt_next     = wr_cnt;
        store_done_next = 1'b0;
        drop_next       = save_enable && !wr_accept;
        case (state)
            FILL: begin
                if (wr_accept) begin
                    if (wr_cnt == LAST_CNT) begin
                        state_next      = HOLD;
                        wr_cnt_next     = '0;
                        store_done_next = 1'b1;
                    end else begin
                        wr_cnt_next = wr_cnt + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (layer3_calculation_done) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= FILL;
            wr_cnt           <= '0;
            pixel_store_done <= 1'b0;
            write_drop       <= 1'b0;
        end else begin
            state            <= state_next;
            wr_cnt           <= wr_cnt_next;
            pixel_store_done <= store_done_next;
            write_drop       <= drop_next;
        end
    end

    // Bank storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            case (wr_bank)
                2'b00:   bank_ee[wr_addr] <= save_data;
                2'b01:   bank_eo[wr_addr] <= save_data;
                2'b10:   bank_oe[wr_addr] <= save_data;
                default: bank_oo[wr_addr] <= save_data;
            endcase
        end
    end

    // Read-first: a same-edge write to the addressed word is not visible here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            input_data_even_even <= '0;
            input_data_even_odd  <= '0;
            input_data_odd_even  <= '0;
            input_data_odd_odd   <= '0;
        end else if (read_pixel_signal) begin
            if (rd_valid) begin
                input_data_even_even <= bank_ee[rd_addr];
                input_data_even_odd  <= bank_eo[rd_addr];
                input_data_odd_even  <= bank_oe[rd_addr];
                input_data_odd_odd   <= bank_oo[rd_addr];
            end else begin
                input_data_even_even <= '0;
                input_data_even_odd  <= '0;
                input_data_odd_even  <= '0;
                input_data_odd_odd   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_layer3_pool_pixel_buffer.sv
// Directed bench for layer3_pool_pixel_buffer: a reference model of the frame memory and
// fill/hold control predicts every output; read results go through a scoreboard queue.
module tb_layer3_pool_pixel_buffer;

    localparam int DW    = 128;
    localparam int R     = 16;
    localparam int C     = 16;
    localparam int AW    = 16;
    localparam int TOTAL = R * C;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          save_enable = 1'b0;
    logic [AW-1:0] save_row = '0;
    logic [AW-1:0] save_col = '0;
    logic [DW-1:0] save_data = '0;
    logic          read_pixel_signal = 1'b0;
    logic [AW-1:0] read_row_addr = '0;
    logic [AW-1:0] read_col_addr = '0;
    logic          layer3_calculation_done = 1'b0;
    logic          pixel_store_done;
    logic [DW-1:0] input_data_even_even;
    logic [DW-1:0] input_data_even_odd;
    logic [DW-1:0] input_data_odd_even;
    logic [DW-1:0] input_data_odd_odd;
    logic          write_drop;

    layer3_pool_pixel_buffer #(
        .DATA_W (DW),
        .IN_ROWS(R),
        .IN_COLS(C),
        .ADDR_W (AW)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .save_enable            (save_enable),
        .save_row               (save_row),
        .save_col               (save_col),
        .save_data              (save_data),
        .read_pixel_signal      (read_pixel_signal),
        .read_row_addr          (read_row_addr),
        .read_col_addr          (read_col_addr),
        .layer3_calculation_done(layer3_calculation_done),
        .pixel_store_done       (pixel_store_done),
        .input_data_even_even   (input_data_even_even),
        .input_data_even_odd    (input_data_even_odd),
        .input_data_odd_even    (input_data_odd_even),
        .input_data_odd_odd     (input_data_odd_odd),
        .write_drop             (write_drop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] ee;
        logic [DW-1:0] eo;
        logic [DW-1:0] oe;
        logic [DW-1:0] oo;
    } win_t;

    typedef enum {M_FILL, M_HOLD} mstate_t;

    win_t          sbq[$];
    win_t          curExp = '0;
    logic [DW-1:0] mMem [R][C];
    mstate_t       mState = M_FILL;
    int            mCnt = 0;
    logic          expDone = 1'b0;
    logic          expDrop = 1'b0;
    int            testsRun = 0;
    int            failCount = 0;
    logic [DW-1:0] ones = '1;

    task automatic cmp(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int r, input int c, input int frame);
        logic [15:0] v;
        v = 16'(frame * 16'h1000 + r * 16 + c);
        return {8{v}};
    endfunction

    function automatic win_t modelWindow(input int r, input int c);
        win_t w;
        w = '0;
        if (r < R / 2 && c < C / 2) begin
            w.ee = mMem[2*r][2*c];
            w.eo = mMem[2*r][2*c+1];
            w.oe = mMem[2*r+1][2*c];
            w.oo = mMem[2*r+1][2*c+1];
        end
        return w;
    endfunction

    task automatic checkOutput();
        cmp("store_done", DW'(pixel_store_done), DW'(expDone));
        cmp("write_drop", DW'(write_drop), DW'(expDrop));
        cmp("even_even", input_data_even_even, curExp.ee);
        cmp("even_odd", input_data_even_odd, curExp.eo);
        cmp("odd_even", input_data_odd_even, curExp.oe);
        cmp("odd_odd", input_data_odd_odd, curExp.oo);
    endtask

    // Predict from the inputs present before the edge, then sample 1 time unit after it.
    task automatic step();
        logic accept;
        accept  = save_enable && mState == M_FILL && int'(save_row) < R && int'(save_col) < C;
        expDrop = save_enable && !accept;
        expDone = accept && mCnt == TOTAL - 1;
        if (read_pixel_signal)
            sbq.push_back(modelWindow(int'(read_row_addr), int'(read_col_addr)));
        if (mState == M_HOLD) begin
            if (layer3_calculation_done) mState = M_FILL;
        end else if (accept) begin
            mMem[save_row][save_col] = save_data;
            mCnt++;
            if (mCnt == TOTAL) begin
                mState = M_HOLD;
                mCnt   = 0;
            end
        end
        @(posedge clk);
        #1;
        if (sbq.size() > 0) curExp = sbq.pop_front();
        checkOutput();
    endtask

    task automatic applyStimulus(input logic en, input int row, input int col,
                                 input logic [DW-1:0] data, input logic rd,
                                 input int rr, input int rc, input logic calc);
        save_enable             = en;
        save_row                = AW'(row);
        save_col                = AW'(col);
        save_data               = data;
        read_pixel_signal       = rd;
        read_row_addr           = AW'(rr);
        read_col_addr           = AW'(rc);
        layer3_calculation_done = calc;
        step();
    endtask

    task automatic writePix(input int row, input int col, input logic [DW-1:0] data);
        applyStimulus(1'b1, row, col, data, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic readWin(input int r, input int c);
        applyStimulus(1'b0, 0, 0, '0, 1'b1, r, c, 1'b0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 0, 0, '0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic doReset();
        save_enable             = 1'b0;
        read_pixel_signal       = 1'b0;
        layer3_calculation_done = 1'b0;
        rst = 1'b1;
        #2;
        mState  = M_FILL;
        mCnt    = 0;
        curExp  = '0;
        expDone = 1'b0;
        expDrop = 1'b0;
        sbq.delete();
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1;
        doReset();

        // Out-of-range writes in FILL are dropped and not counted.
        writePix(16, 0, ones);
        writePix(0, 16, ones);

        // Same-cycle write and read of one word returns the old value.
        writePix(0, 0, pix(0, 0, 0));
        writePix(0, 1, pix(0, 1, 0));
        writePix(1, 0, pix(1, 0, 0));
        writePix(1, 1, pix(1, 1, 0));
        applyStimulus(1'b1, 0, 0, ones, 1'b1, 0, 0, 1'b0);
        cmp("read_first_old", input_data_even_even, pix(0, 0, 0));
        readWin(0, 0);
        cmp("read_after_write", input_data_even_even, ones);

        // 100 writes in total, then reset abandons the partial frame.
        for (int i = 1; i < 96; i++) writePix(i / C, i % C, pix(i / C, i % C, 0));
        doReset();

        // Full frame; the completing write coincides with calculation-done and must win.
        for (int i = 0; i < TOTAL - 1; i++) writePix(i / C, i % C, pix(i / C, i % C, 0));
        applyStimulus(1'b1, R - 1, C - 1, pix(R - 1, C - 1, 0), 1'b0, 0, 0, 1'b1);
        cmp("done_pulse", DW'(pixel_store_done), DW'(1'b1));
        idle();
        idle();

        // HOLD rejects writes and leaves memory unchanged.
        writePix(0, 0, ones);
        writePix(6, 10, ones);
        readWin(3, 5);
        cmp("win35_ee", input_data_even_even, {8{16'h006A}});
        cmp("win35_eo", input_data_even_odd,  {8{16'h006B}});
        cmp("win35_oe", input_data_odd_even,  {8{16'h007A}});
        cmp("win35_oo", input_data_odd_odd,   {8{16'h007B}});
        for (int w = 0; w < (R / 2) * (C / 2); w++) readWin(w / (C / 2), w % (C / 2));
        readWin(8, 0);
        readWin(0, 8);
        idle();

        // Write coincident with calculation-done in HOLD is dropped; buffer rearms.
        applyStimulus(1'b1, 2, 2, ones, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < TOTAL; i++) begin
            if (i == 50)
                applyStimulus(1'b1, i / C, i % C, pix(i / C, i % C, 1), 1'b1, 1, 1, 1'b1);
            else
                writePix(i / C, i % C, pix(i / C, i % C, 1));
        end
        idle();
        for (int w = 0; w < (R / 2) * (C / 2); w++) readWin(w / (C / 2), w % (C / 2));
        readWin(8, 0);
        idle();
        readWin(7, 7);
        idle();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
